// File: rtl/xor_pkg.sv
// xor_pkg: shared types and constants for the XOR core load sequencer.
//   seq_state_t  - sequencer FSM state encoding
//   XOR_KEY_W    - key length of the XOR core in bits
//   XOR_MSG_W    - message length of the XOR core in bits
//   UI_* / UO_*  - bit positions of the core's ui_in / uo_out pins
package xor_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StKey,
      StGap,
      StMsg,
      StWaitCore
   } seq_state_t;

   localparam int unsigned XOR_KEY_W = 8;
   localparam int unsigned XOR_MSG_W = 64;

   localparam int unsigned UI_SERIAL_BIT   = 0;
   localparam int unsigned UI_LOAD_KEY_BIT = 1;
   localparam int unsigned UI_LOAD_MSG_BIT = 2;
   localparam int unsigned UO_OUT_STAT_BIT = 1;

endpackage

// File: rtl/xor_piso.sv
// xor_piso: parallel-in, serial-out shift register, LSB first.
//   i_clk   - clock
//   i_rst   - synchronous active-high reset
//   i_load  - capture i_data (has priority over i_shift)
//   i_shift - shift right by one, exposing the next bit on o_lsb
//   i_data  - parallel word
//   o_lsb   - bit currently at position 0
module xor_piso #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_lsb
);

   logic [WIDTH-1:0] r_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end else if (i_shift) begin
         r_data <= {1'b0, r_data[WIDTH-1:1]};
      end
   end

   assign o_lsb = r_data[0];

endmodule

// File: rtl/xor_load_sequencer.sv
// xor_load_sequencer: accepts a parallel key/message transaction and drives the
// XOR core's serial load protocol (LSB first), then waits for the core to finish.
//   iClk, iRst        - clock, synchronous active-high reset
//   iEn               - enable; low freezes an in-flight sequence
//   iStart            - transaction valid (taken only while oReady)
//   iKey, iMsg        - key and message words
//   iSkip_Key         - reuse the key already in the core
//   iCore_Busy        - core output-status line
//   oReady            - idle and able to take iStart
//   oSerial           - serial data bit to the core
//   oLoad_Key/Msg     - load strobes to the core
//   oDone, oError     - end-of-transaction pulse, timeout flag with it
module xor_load_sequencer
   import xor_pkg::*;
#(
   parameter int unsigned KEY_WIDTH  = XOR_KEY_W,
   parameter int unsigned MSG_WIDTH  = XOR_MSG_W,
   parameter int unsigned GAP_CYCLES = 1,
   parameter int unsigned TIMEOUT    = 256
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iEn,
   input  logic                 iStart,
   input  logic [KEY_WIDTH-1:0] iKey,
   input  logic [MSG_WIDTH-1:0] iMsg,
   input  logic                 iSkip_Key,
   input  logic                 iCore_Busy,
   output logic                 oReady,
   output logic                 oSerial,
   output logic                 oLoad_Key,
   output logic                 oLoad_Msg,
   output logic                 oDone,
   output logic                 oError
);

   localparam int unsigned CNT_W = $clog2(MSG_WIDTH);
   localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_WIDTH - 1);
   localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = '1;

   seq_state_t       r_state, w_state_d;
   logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_d;
   logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_d;
   logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_d;
   logic             r_seen_busy, w_seen_busy_d;
   logic             r_key_loaded, w_key_loaded_d;

   logic r_ready, w_ready_d;
   logic r_serial, w_serial_d;
   logic r_load_key, w_load_key_d;
   logic r_load_msg, w_load_msg_d;
   logic r_done, w_done_d;
   logic r_error, w_error_d;

   logic w_load, w_key_shift, w_msg_shift;
   logic w_key_bit, w_msg_bit;

   xor_piso #(
      .WIDTH (KEY_WIDTH)
   ) u_key_piso (
      .i_clk   (iClk),
      .i_rst   (iRst),
      .i_load  (w_load),
      .i_shift (w_key_shift),
      .i_data  (iKey),
      .o_lsb   (w_key_bit)
   );

   xor_piso #(
      .WIDTH (MSG_WIDTH)
   ) u_msg_piso (
      .i_clk   (iClk),
      .i_rst   (iRst),
      .i_load  (w_load),
      .i_shift (w_msg_shift),
      .i_data  (iMsg),
      .o_lsb   (w_msg_bit)
   );

   // Every clock with iEn high in KEY/MSG emits exactly one bit onto the registered
   // outputs and advances the counter; with iEn low nothing is emitted and nothing
   // advances, so the next unsent bit is the one presented on resume.
   always_comb begin
      w_state_d      = r_state;
      w_bit_cnt_d    = r_bit_cnt;
      w_gap_cnt_d    = r_gap_cnt;
      w_tmo_cnt_d    = r_tmo_cnt;
      w_seen_busy_d  = r_seen_busy;
      w_key_loaded_d = r_key_loaded;
      w_serial_d     = r_serial;
      w_load_key_d   = 1'b0;
      w_load_msg_d   = 1'b0;
      w_done_d       = 1'b0;
      w_error_d      = 1'b0;
      w_load         = 1'b0;
      w_key_shift    = 1'b0;
      w_msg_shift    = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (iStart && iEn) begin
               w_load        = 1'b1;
               w_bit_cnt_d   = '0;
               w_gap_cnt_d   = '0;
               w_seen_busy_d = 1'b0;
               // Skipping is only legal once the core actually holds a key.
               w_state_d     = (iSkip_Key && r_key_loaded) ? StMsg : StKey;
            end
         end

         StKey: begin
            if (iEn) begin
               w_load_key_d = 1'b1;
               w_serial_d   = w_key_bit;
               w_key_shift  = 1'b1;
               if (r_bit_cnt == KEY_LAST) begin
                  w_bit_cnt_d    = '0;
                  w_key_loaded_d = 1'b1;
                  w_state_d      = (GAP_CYCLES == 0) ? StMsg : StGap;
               end else begin
                  w_bit_cnt_d = r_bit_cnt + 1'b1;
               end
            end
         end

         StGap: begin
            if (iEn) begin
               if (r_gap_cnt == GAP_LAST) begin
                  w_gap_cnt_d = '0;
                  w_state_d   = StMsg;
               end else begin
                  w_gap_cnt_d = r_gap_cnt + 1'b1;
               end
            end
         end

         StMsg: begin
            if (iEn) begin
               w_load_msg_d = 1'b1;
               w_serial_d   = w_msg_bit;
               w_msg_shift  = 1'b1;
               if (r_bit_cnt == MSG_LAST) begin
                  w_bit_cnt_d   = '0;
                  w_tmo_cnt_d   = '0;
                  w_seen_busy_d = 1'b0;
                  w_state_d     = StWaitCore;
               end else begin
                  w_bit_cnt_d = r_bit_cnt + 1'b1;
               end
            end
         end

         StWaitCore: begin
            if (iEn) begin
               // A busy-then-idle completion wins over a coincident timeout.
               if (r_seen_busy && !iCore_Busy) begin
                  w_done_d  = 1'b1;
                  w_state_d = StIdle;
               end else if (r_tmo_cnt == TMO_LAST) begin
                  w_done_d  = 1'b1;
                  w_error_d = 1'b1;
                  w_state_d = StIdle;
               end else begin
                  if (iCore_Busy) begin
                     w_seen_busy_d = 1'b1;
                  end
                  if (r_tmo_cnt != TMO_MAX) begin
                     w_tmo_cnt_d = r_tmo_cnt + 1'b1;
                  end
               end
            end
         end

         default: begin
            w_state_d = StIdle;
         end
      endcase

      w_ready_d = (w_state_d == StIdle);
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state      <= StIdle;
         r_bit_cnt    <= '0;
         r_gap_cnt    <= '0;
         r_tmo_cnt    <= '0;
         r_seen_busy  <= 1'b0;
         r_key_loaded <= 1'b0;
         r_ready      <= 1'b1;
         r_serial     <= 1'b0;
         r_load_key   <= 1'b0;
         r_load_msg   <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_bit_cnt    <= w_bit_cnt_d;
         r_gap_cnt    <= w_gap_cnt_d;
         r_tmo_cnt    <= w_tmo_cnt_d;
         r_seen_busy  <= w_seen_busy_d;
         r_key_loaded <= w_key_loaded_d;
         r_ready      <= w_ready_d;
         r_serial     <= w_serial_d;
         r_load_key   <= w_load_key_d;
         r_load_msg   <= w_load_msg_d;
         r_done       <= w_done_d;
         r_error      <= w_error_d;
      end
   end

   assign oReady    = r_ready;
   assign oSerial   = r_serial;
   assign oLoad_Key = r_load_key;
   assign oLoad_Msg = r_load_msg;
   assign oDone     = r_done;
   assign oError    = r_error;

endmodule

// File: tb/tb_xor_load_sequencer.sv
// tb_xor_load_sequencer: scoreboard bench for xor_load_sequencer. Expected serial
// stream entries are queued when a transaction is issued and popped on every strobe.
module tb_xor_load_sequencer;

   logic        clk;
   logic        iRst;
   logic        iEn;
   logic        iStart;
   logic [7:0]  iKey;
   logic [63:0] iMsg;
   logic        iSkip_Key;
   logic        iCore_Busy;
   logic        oReady;
   logic        oSerial;
   logic        oLoad_Key;
   logic        oLoad_Msg;
   logic        oDone;
   logic        oError;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Entry = {load_key, load_msg, serial}
   logic [2:0] sb_q[$];
   logic       m_key_loaded;

   int first_key, last_key, n_key, first_msg, last_msg, n_msg, end_idx;

   xor_load_sequencer #(
      .KEY_WIDTH  (8),
      .MSG_WIDTH  (64),
      .GAP_CYCLES (1),
      .TIMEOUT    (256)
   ) dut (
      .iClk       (clk),
      .iRst       (iRst),
      .iEn        (iEn),
      .iStart     (iStart),
      .iKey       (iKey),
      .iMsg       (iMsg),
      .iSkip_Key  (iSkip_Key),
      .iCore_Busy (iCore_Busy),
      .oReady     (oReady),
      .oSerial    (oSerial),
      .oLoad_Key  (oLoad_Key),
      .oLoad_Msg  (oLoad_Msg),
      .oDone      (oDone),
      .oError     (oError)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every strobe cycle must match the next queued entry.
   always @(negedge clk) begin
      if (oLoad_Key || oLoad_Msg) begin
         logic [2:0] exp;
         exp = (sb_q.size() > 0) ? sb_q.pop_front() : 3'b000;
         check_eq("stream bit", 64'({oLoad_Key, oLoad_Msg, oSerial}), 64'(exp));
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, " oReady"}, 64'(oReady), 64'(1));
      check_eq({tag, " oSerial"}, 64'(oSerial), 64'(0));
      check_eq({tag, " oLoad_Key"}, 64'(oLoad_Key), 64'(0));
      check_eq({tag, " oLoad_Msg"}, 64'(oLoad_Msg), 64'(0));
      check_eq({tag, " oDone"}, 64'(oDone), 64'(0));
      check_eq({tag, " oError"}, 64'(oError), 64'(0));
   endtask

   // Called at a negedge while idle; returns at the negedge of the acceptance cycle.
   task automatic start_txn(input logic [7:0] key, input logic [63:0] msg, input logic skip);
      check_eq("ready before start", 64'(oReady), 64'(1));
      iStart    = 1'b1;
      iKey      = key;
      iMsg      = msg;
      iSkip_Key = skip;
      if (!(skip && m_key_loaded)) begin
         for (int i = 0; i < 8; i++) sb_q.push_back({2'b10, key[i]});
      end
      for (int i = 0; i < 64; i++) sb_q.push_back({2'b01, msg[i]});
      @(negedge clk);
      iStart    = 1'b0;
      iSkip_Key = 1'b0;
      check_eq("ready drops", 64'(oReady), 64'(0));
      check_eq("no done at start", 64'(oDone), 64'(0));
   endtask

   // Walks the load phases, recording strobe positions relative to acceptance (idx 0).
   task automatic run_load(input int pause_at, input logic [63:0] msg);
      int idx;
      idx       = 0;
      first_key = -1; last_key = -1; n_key = 0;
      first_msg = -1; last_msg = -1; n_msg = 0;
      while (idx < 300 && !(n_msg == 64 && !oLoad_Msg)) begin
         @(negedge clk);
         idx++;
         if (oLoad_Key) begin
            if (n_key == 0) first_key = idx;
            last_key = idx;
            n_key++;
         end
         if (oLoad_Msg) begin
            if (n_msg == 0) first_msg = idx;
            last_msg = idx;
            n_msg++;
            if (n_msg == pause_at) begin
               iEn = 1'b0;
               for (int p = 0; p < 5; p++) begin
                  @(negedge clk);
                  idx++;
                  check_eq("pause strobes", 64'({oLoad_Key, oLoad_Msg}), 64'(0));
                  check_eq("pause serial hold", 64'(oSerial), 64'(msg[pause_at-1]));
               end
               iEn = 1'b1;
            end
         end
      end
      end_idx = idx;
   endtask

   task automatic core_handshake(input int busy_len);
      int early;
      early      = 0;
      iCore_Busy = 1'b1;
      repeat (busy_len) begin
         @(negedge clk);
         if (oDone) early++;
      end
      check_eq("no done while busy", 64'(early), 64'(0));
      iCore_Busy = 1'b0;
      @(negedge clk);
      check_eq("done after busy falls", 64'(oDone), 64'(1));
      check_eq("no error on completion", 64'(oError), 64'(0));
      check_eq("ready with done", 64'(oReady), 64'(1));
   endtask

   initial begin
      int k, err_early, done_cnt;
      logic [63:0] msg;

      iRst = 1'b1; iEn = 1'b1; iStart = 1'b0; iKey = '0; iMsg = '0;
      iSkip_Key = 1'b0; iCore_Busy = 1'b0; m_key_loaded = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      iRst = 1'b0;
      @(negedge clk);

      // Skip requested straight after reset: no key loaded yet, so key phase runs.
      msg = 64'hA3B1F9D2E7C6A594;
      start_txn(8'hA5, msg, 1'b1);
      run_load(0, msg);
      check_eq("full first key", 64'(first_key), 64'(1));
      check_eq("full last key", 64'(last_key), 64'(8));
      check_eq("full key count", 64'(n_key), 64'(8));
      check_eq("full first msg", 64'(first_msg), 64'(10));
      check_eq("full last msg", 64'(last_msg), 64'(73));
      check_eq("full msg count", 64'(n_msg), 64'(64));
      m_key_loaded = 1'b1;
      core_handshake(64);

      // Back-to-back skip-key transaction, then the core never goes busy.
      msg = 64'h0123456789ABCDEF;
      start_txn(8'hFF, msg, 1'b1);
      run_load(0, msg);
      check_eq("skip key count", 64'(n_key), 64'(0));
      check_eq("skip first msg", 64'(first_msg), 64'(1));
      check_eq("skip last msg", 64'(last_msg), 64'(64));
      check_eq("skip msg count", 64'(n_msg), 64'(64));
      k = -1;
      err_early = 0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (oDone) begin
            k = end_idx + c;
            break;
         end
         if (oError) err_early++;
      end
      // WAIT_CORE entered at the last message edge; counter then runs 0..255.
      check_eq("timeout done idx", 64'(k), 64'(last_msg + 256));
      check_eq("timeout error", 64'(oError), 64'(1));
      check_eq("timeout ready", 64'(oReady), 64'(1));
      check_eq("no early error", 64'(err_early), 64'(0));
      @(negedge clk);
      check_eq("done single pulse", 64'({oDone, oError}), 64'(0));

      // Pause for five cycles after message bit 19.
      msg = {$urandom, $urandom};
      start_txn(8'h3C, msg, 1'b0);
      run_load(20, msg);
      check_eq("pause key count", 64'(n_key), 64'(8));
      check_eq("pause first msg", 64'(first_msg), 64'(10));
      check_eq("pause last msg", 64'(last_msg), 64'(78));
      check_eq("pause msg count", 64'(n_msg), 64'(64));
      core_handshake(3);
      @(negedge clk);

      // Reset while key bit 3 is on the wire.
      msg = {$urandom, $urandom};
      start_txn(8'h5A, msg, 1'b0);
      repeat (4) @(negedge clk);
      check_eq("key bit 3 strobe", 64'(oLoad_Key), 64'(1));
      iRst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid-key reset");
      check_eq("abandoned entries", 64'(sb_q.size()), 64'(68));
      sb_q.delete();
      m_key_loaded = 1'b0;
      iRst = 1'b0;
      done_cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (oDone) done_cnt++;
      end
      check_eq("no done after reset", 64'(done_cnt), 64'(0));

      // Key flag cleared by reset: skip request must reload the key.
      msg = {$urandom, $urandom};
      start_txn(8'hC3, msg, 1'b1);
      run_load(0, msg);
      check_eq("post-reset key count", 64'(n_key), 64'(8));
      check_eq("post-reset first msg", 64'(first_msg), 64'(10));
      core_handshake(10);

      @(negedge clk);
      check_eq("scoreboard drained", 64'(sb_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/xor_load_sequencer.md
# xor_load_sequencer

Upstream feeder for the XOR encryption core (`tt_um_franco_mezzarapa`). It accepts a parallel 8-bit key and 64-bit message through a valid/ready handshake. It then drives the core's serial load protocol: serial data bit, key-load strobe and message-load strobe, all LSB-first. It also watches the core's output-status line to report completion. This lets a host or test harness issue one transaction per message instead of bit-banging `ui_in`.

## Interface
Parameters:
- `KEY_WIDTH`, 8, key length in bits
- `MSG_WIDTH`, 64, message length in bits
- `GAP_CYCLES`, 1, idle cycles between key phase and message phase
- `TIMEOUT`, 256, maximum cycles waited for the core to finish

Ports:
- `iClk`  in  1  clock; the block uses one clock only
- `iRst`  in  1  reset; synchronous and active-high
- `iEn`  in  1  enable; low pauses the sequence
- `iStart`  in  1  transaction valid
- `iKey`  in  KEY_WIDTH  key word
- `iMsg`  in  MSG_WIDTH  message word
- `iSkip_Key`  in  1  reuse the previously loaded key
- `iCore_Busy`  in  1  core output-status line (`uo_out[1]`)
- `oReady`  out  1  block can accept `iStart`
- `oSerial`  out  1  serial data to the core (`ui_in[0]`)
- `oLoad_Key`  out  1  key-load strobe (`ui_in[1]`)
- `oLoad_Msg`  out  1  message-load strobe (`ui_in[2]`)
- `oDone`  out  1  one-cycle pulse at end of transaction
- `oError`  out  1  one-cycle pulse with `oDone` on timeout

## Operation
- **FSM states:** IDLE, KEY, GAP, MSG, WAIT_CORE.
- **IDLE**
  - `oReady`=1.
  - `iStart`&&`iEn` captures `iKey`, `iMsg` and `iSkip_Key` into shadow registers.
  - Next state is KEY. It is MSG if the skip flag is set and a key has been loaded since reset.
  - If no key has been loaded since reset, `iSkip_Key` is ignored.
- **KEY**
  - `oLoad_Key`=1 and `oSerial`=key[bit_cnt], bit_cnt running 0..KEY_WIDTH-1.
  - After the last bit, sets the key_loaded flag and goes to GAP.
- **GAP**
  - All strobes are 0 for GAP_CYCLES cycles, then the FSM goes to MSG.
  - GAP_CYCLES=0 means KEY goes directly to MSG.
- **MSG**
  - `oLoad_Msg`=1 and `oSerial`=msg[bit_cnt], bit_cnt running 0..MSG_WIDTH-1.
  - After the last bit, goes to WAIT_CORE and clears the timeout counter.
- **WAIT_CORE**
  - Tracks a seen_busy flag.
  - When `iCore_Busy` is observed high and then low, pulses `oDone` and returns to IDLE.
  - When the timeout counter reaches TIMEOUT-1 first, pulses `oDone` and `oError` together and returns to IDLE.
- **`iEn` low, any non-IDLE state**
  - bit_cnt, gap counter and timeout counter freeze.
  - `oLoad_Key`/`oLoad_Msg` are forced 0; `oSerial` holds its value.
  - The current bit is re-presented when `iEn` returns, so no bit is lost or duplicated.
- **Handshake:** `iStart` outside IDLE is ignored; no queueing.
- **Counters:** bit_cnt is $clog2(MSG_WIDTH) bits and is reused by both phases. The timeout counter is $clog2(TIMEOUT)+1 bits and saturates.

## Timing
- **Reset values:** `oReady`=1, `oSerial`=0, `oLoad_Key`=0, `oLoad_Msg`=0, `oDone`=0, `oError`=0. State is IDLE and key_loaded=0.
- **`iRst` mid-transaction:** returns to IDLE on the next edge with strobes low. No `oDone` is issued and key_loaded is cleared.
- **All outputs are registered.** `oReady` is registered from the next-state value, so it drops the cycle after acceptance.
- **Full transaction latency, accepted at edge N (`iEn` held high):**
  - Key bits on cycles N+1..N+8.
  - Gap at N+9.
  - Message bits on N+10..N+73.
  - WAIT_CORE from N+74.
- **Skip-key transaction:** message bits on N+1..N+64.
- **`oDone`:** asserted the cycle after `iCore_Busy` is sampled low with seen_busy=1.
- **Back-to-back:** a new `iStart` can be accepted the cycle after `oDone`.

## Structure
- **Package `xor_pkg`:**
  - State enum `seq_state_t`.
  - Localparams `XOR_KEY_W`=8 and `XOR_MSG_W`=64.
  - Status bit positions for `ui_in`/`uo_out` (serial=0, load_key/out_stat=1, load_msg=2).
- **Sub-module `xor_piso`:**
  - Parallel-in, serial-out shift register parametrised by width.
  - Has load, shift-enable and LSB output.
  - Instantiated once for key and once for message.
- The FSM and counters live in the top level.

## Test plan
- **Full load:** reset, then `iStart` with key=8'hA5, msg=64'hA3B1F9D2E7C6A594.
  - Key phase: `oSerial` = 1,0,1,0,0,1,0,1 with `oLoad_Key`=1 for exactly 8 cycles.
  - Gap: one cycle with both strobes 0.
  - Message phase: first 8 bits 0,0,1,0,1,0,0,1 with `oLoad_Msg`=1 for exactly 64 cycles.
  - Reassembled bits equal the inputs.
- **Core handshake:** model `iCore_Busy` high for 64 cycles after the message phase. Expect `oDone`=1 for one cycle, one cycle after busy falls, with `oError`=0 and `oReady` back to 1.
- **Skip key:** a second transaction with `iSkip_Key`=1 and msg=64'h0123456789ABCDEF gives no `oLoad_Key` cycles and message bits starting at N+1. The same request issued right after reset runs the key phase instead.
- **Pause:** drop `iEn` for 5 cycles at message bit 20. Strobes are 0 during the pause and the full 64-bit stream is still exact with no repeated bit.
- **Timeout:** hold `iCore_Busy`=0 after the message phase. Expect `oDone` and `oError` pulsed together 256 cycles after entering WAIT_CORE.
- **Reset mid-key:** assert `iRst` at key bit 3. All outputs return to reset values on the next edge, no `oDone` is issued, and the next transaction with `iSkip_Key`=1 still performs the key phase.
